// File: rtl/multicycle_control.sv
// multicycle_control
//   Control FSM for a multicycle MIPS-style datapath. Sequences fetch, decode,
//   execute, memory and write-back steps, and drives the datapath mux selects
//   and write enables.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   op[5:0]                    opcode from the instruction register
//   zero                       ALU zero flag (branch condition)
//   mem_ready                  memory access completes this cycle
//   pc_en, pc_src[1:0]         PC write enable / PC source select
//   i_or_d, mem_read,          memory address select / read strobe /
//   mem_write, ir_write        write strobe (never used) / IR load
//   reg_dst, mem_to_reg,       register file destination / data select /
//   reg_write                  write enable
//   alu_src_a, alu_src_b,      ALU operand selects and operation
//   alu_op[2:0]
//   state[3:0], retire         current state / last cycle of an instruction
//   illegal_op, mem_timeout    sticky error flags, cleared only by reset
//
// state    | meaning
// ---------+------------------------------------------------
// FETCH    | read instruction, PC <= PC + 4 when memory ready
// DECODE   | latch opcode, branch target into ALUOut
// MEM_ADDR | compute load address
// MEM_READ | read data memory, wait for mem_ready
// MEM_WB   | load data to rt
// EXEC_R   | R-type ALU operation
// EXEC_I   | immediate ALU operation
// ALU_WB   | ALU result to rd / rt
// BRANCH   | compare, conditional PC <= ALUOut
// JUMP     | PC <= jump target, JAL links r31
// ERROR    | illegal opcode or memory timeout, held until reset

module multicycle_control #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic [1:0] pc_src,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [3:0] state,
    output logic       retire,
    output logic       illegal_op,
    output logic       mem_timeout
);

    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEM_ADDR = 4'd2;
    localparam logic [3:0] MEM_READ = 4'd3;
    localparam logic [3:0] MEM_WB   = 4'd4;
    localparam logic [3:0] EXEC_R   = 4'd5;
    localparam logic [3:0] EXEC_I   = 4'd6;
    localparam logic [3:0] ALU_WB   = 4'd7;
    localparam logic [3:0] BRANCH   = 4'd8;
    localparam logic [3:0] JUMP     = 4'd9;
    localparam logic [3:0] ERROR    = 4'd10;

    localparam int             WW        = $clog2(WAIT_LIMIT + 1);
    localparam logic [WW-1:0]  WAIT_MAX  = WW'(WAIT_LIMIT);
    localparam logic [WW-1:0]  WAIT_LAST = WW'(WAIT_LIMIT - 1);

    logic [3:0]    state_q, state_d;
    logic [5:0]    op_q, op_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          illegal_q, illegal_d;
    logic          timeout_q, timeout_d;
    logic          waiting;
    logic          timeout_hit;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        wait_d    = '0;

        waiting     = ((state_q == FETCH) || (state_q == MEM_READ)) && !mem_ready;
        // wait_q counts earlier wait cycles, so this is the WAIT_LIMIT-th one
        timeout_hit = waiting && (wait_q >= WAIT_LAST);

        case (state_q)
            FETCH:    if (mem_ready) state_d = DECODE;
            DECODE: begin
                op_d = op;
                case (op)
                    6'h00:                      state_d = EXEC_R;
                    6'h08, 6'h0D, 6'h0C, 6'h0F: state_d = EXEC_I;
                    6'h23:                      state_d = MEM_ADDR;
                    6'h04, 6'h05:               state_d = BRANCH;
                    6'h02, 6'h03:               state_d = JUMP;
                    default: begin
                        state_d   = ERROR;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            MEM_ADDR: state_d = MEM_READ;
            MEM_READ: if (mem_ready) state_d = MEM_WB;
            EXEC_R,
            EXEC_I:   state_d = ALU_WB;
            MEM_WB,
            ALU_WB,
            BRANCH,
            JUMP:     state_d = FETCH;
            ERROR:    state_d = ERROR;
            default:  state_d = ERROR;
        endcase

        if (timeout_hit) begin
            state_d   = ERROR;
            timeout_d = 1'b1;
        end else if (waiting) begin
            wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= FETCH;
            op_q      <= '0;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        pc_en      = 1'b0;
        pc_src     = 2'b00;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 3'b010;
        retire     = 1'b0;

        case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_op    = 3'b011;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                alu_op    = 3'b011;
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 3'b011;
            end
            MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
                retire     = 1'b1;
            end
            EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = 3'b111;
            end
            EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                case (op_q)
                    6'h0D:   alu_op = 3'b101;
                    6'h0C:   alu_op = 3'b110;
                    6'h0F:   alu_op = 3'b000;
                    default: alu_op = 3'b100;
                endcase
            end
            ALU_WB: begin
                reg_write = 1'b1;
                reg_dst   = (op_q == 6'h00) ? 2'b01 : 2'b00;
                retire    = 1'b1;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 3'b001;
                pc_src    = 2'b01;
                pc_en     = ((op_q == 6'h04) && zero) || ((op_q == 6'h05) && !zero);
                retire    = 1'b1;
            end
            JUMP: begin
                pc_src = 2'b10;
                pc_en  = 1'b1;
                retire = 1'b1;
                if (op_q == 6'h03) begin
                    reg_write  = 1'b1;
                    reg_dst    = 2'b10;
                    mem_to_reg = 2'b10;
                end
            end
            default: ;
        endcase

        // state_q is already FETCH under reset; only the strobes need masking
        if (reset) begin
            pc_en     = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end
    end

    assign state       = state_q;
    assign illegal_op  = illegal_q;
    assign mem_timeout = timeout_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    typedef struct packed {
        logic       pc_en;
        logic [1:0] pc_src;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       retire;
    } ctl_t;

    typedef struct packed {
        logic [5:0] op;
        logic       zero;
        logic       mr;
        logic [3:0] st;
        ctl_t       ctl;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] op = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_en, i_or_d, mem_read, mem_write, ir_write, reg_write;
    logic       alu_src_a, retire, illegal_op, mem_timeout;
    logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_b;
    logic [2:0] alu_op;
    logic [3:0] state;

    int n_vec = 0;
    int n_bad = 0;

    multicycle_control #(.WAIT_LIMIT(15)) dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .pc_src(pc_src), .i_or_d(i_or_d), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .state(state), .retire(retire),
        .illegal_op(illegal_op), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic ctl_t c(input logic pe, input logic [1:0] ps, input logic iod,
                               input logic mr, input logic irw, input logic [1:0] rd,
                               input logic [1:0] m2r, input logic rw, input logic a,
                               input logic [1:0] b, input logic [2:0] aop, input logic ret);
        ctl_t r;
        r = '{pe, ps, iod, mr, 1'b0, irw, rd, m2r, rw, a, b, aop, ret};
        return r;
    endfunction

    function automatic vec_t mk(input logic [5:0] o, input logic z, input logic m,
                                input logic [3:0] s, input ctl_t k);
        vec_t v;
        v = '{o, z, m, s, k};
        return v;
    endfunction

    function automatic ctl_t act_ctl();
        ctl_t r;
        r = '{pc_en, pc_src, i_or_d, mem_read, mem_write, ir_write, reg_dst,
              mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, retire};
        return r;
    endfunction

    task automatic run(input string name, input vec_t v);
        ctl_t a;
        op        = v.op;
        zero      = v.zero;
        mem_ready = v.mr;
        @(negedge clk);
        a = act_ctl();
        n_vec++;
        if (state !== v.st || a !== v.ctl) begin
            n_bad++;
            $display("FAIL %s: got state=%0d ctl=%h, expected state=%0d ctl=%h",
                     name, state, a, v.st, v.ctl);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    ctl_t F1, F0, DEC, EXR, EI_ADD, EI_OR, EI_AND, EI_LUI, AW_R, AW_I;
    ctl_t MA, MR, MW, BR_T, BR_N, JP, JAL, ERR, RST;
    vec_t tbl[$];

    initial begin
        F1     = c(1, 2'b00, 0, 1, 1, 2'b00, 2'b00, 0, 0, 2'b01, 3'b011, 0);
        F0     = c(0, 2'b00, 0, 1, 0, 2'b00, 2'b00, 0, 0, 2'b01, 3'b011, 0);
        DEC    = c(0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b11, 3'b011, 0);
        EXR    = c(0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b00, 3'b111, 0);
        EI_ADD = c(0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b10, 3'b100, 0);
        EI_OR  = c(0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b10, 3'b101, 0);
        EI_AND = c(0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b10, 3'b110, 0);
        EI_LUI = c(0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b10, 3'b000, 0);
        AW_R   = c(0, 2'b00, 0, 0, 0, 2'b01, 2'b00, 1, 0, 2'b00, 3'b010, 1);
        AW_I   = c(0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 1, 0, 2'b00, 3'b010, 1);
        MA     = c(0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b10, 3'b011, 0);
        MR     = c(0, 2'b00, 1, 1, 0, 2'b00, 2'b00, 0, 0, 2'b00, 3'b010, 0);
        MW     = c(0, 2'b00, 0, 0, 0, 2'b00, 2'b01, 1, 0, 2'b00, 3'b010, 1);
        BR_T   = c(1, 2'b01, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b00, 3'b001, 1);
        BR_N   = c(0, 2'b01, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b00, 3'b001, 1);
        JP     = c(1, 2'b10, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 3'b010, 1);
        JAL    = c(1, 2'b10, 0, 0, 0, 2'b10, 2'b10, 1, 0, 2'b00, 3'b010, 1);
        ERR    = c(0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 3'b010, 0);
        RST    = c(0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b01, 3'b011, 0);

        // R-type; opcode input changed during write-back must not affect reg_dst
        tbl.push_back(mk(6'h00, 0, 1, 4'd0, F1));
        tbl.push_back(mk(6'h00, 0, 1, 4'd1, DEC));
        tbl.push_back(mk(6'h00, 0, 1, 4'd5, EXR));
        tbl.push_back(mk(6'h23, 0, 1, 4'd7, AW_R));
        // ADDI
        tbl.push_back(mk(6'h08, 0, 1, 4'd0, F1));
        tbl.push_back(mk(6'h08, 0, 1, 4'd1, DEC));
        tbl.push_back(mk(6'h08, 0, 1, 4'd6, EI_ADD));
        tbl.push_back(mk(6'h08, 0, 1, 4'd7, AW_I));
        // ORI; live opcode changed in EXEC_I, alu_op must follow latched opcode
        tbl.push_back(mk(6'h0D, 0, 1, 4'd0, F1));
        tbl.push_back(mk(6'h0D, 0, 1, 4'd1, DEC));
        tbl.push_back(mk(6'h00, 0, 1, 4'd6, EI_OR));
        tbl.push_back(mk(6'h0D, 0, 1, 4'd7, AW_I));
        // ANDI, LUI
        tbl.push_back(mk(6'h0C, 0, 1, 4'd0, F1));
        tbl.push_back(mk(6'h0C, 0, 1, 4'd1, DEC));
        tbl.push_back(mk(6'h0C, 0, 1, 4'd6, EI_AND));
        tbl.push_back(mk(6'h0C, 0, 1, 4'd7, AW_I));
        tbl.push_back(mk(6'h0F, 0, 1, 4'd0, F1));
        tbl.push_back(mk(6'h0F, 0, 1, 4'd1, DEC));
        tbl.push_back(mk(6'h0F, 0, 1, 4'd6, EI_LUI));
        tbl.push_back(mk(6'h0F, 0, 1, 4'd7, AW_I));
        // LW: two fetch waits, three MEM_READ waits (MEM_READ held 4 cycles)
        tbl.push_back(mk(6'h23, 0, 0, 4'd0, F0));
        tbl.push_back(mk(6'h23, 0, 0, 4'd0, F0));
        tbl.push_back(mk(6'h23, 0, 1, 4'd0, F1));
        tbl.push_back(mk(6'h23, 0, 1, 4'd1, DEC));
        tbl.push_back(mk(6'h23, 0, 1, 4'd2, MA));
        tbl.push_back(mk(6'h23, 0, 0, 4'd3, MR));
        tbl.push_back(mk(6'h23, 0, 0, 4'd3, MR));
        tbl.push_back(mk(6'h23, 0, 0, 4'd3, MR));
        tbl.push_back(mk(6'h23, 0, 1, 4'd3, MR));
        tbl.push_back(mk(6'h23, 0, 1, 4'd4, MW));
        // BEQ / BNE with both zero values
        tbl.push_back(mk(6'h04, 1, 1, 4'd0, F1));
        tbl.push_back(mk(6'h04, 1, 1, 4'd1, DEC));
        tbl.push_back(mk(6'h04, 1, 1, 4'd8, BR_T));
        tbl.push_back(mk(6'h04, 0, 1, 4'd0, F1));
        tbl.push_back(mk(6'h04, 0, 1, 4'd1, DEC));
        tbl.push_back(mk(6'h04, 0, 1, 4'd8, BR_N));
        tbl.push_back(mk(6'h05, 1, 1, 4'd0, F1));
        tbl.push_back(mk(6'h05, 1, 1, 4'd1, DEC));
        tbl.push_back(mk(6'h05, 1, 1, 4'd8, BR_N));
        tbl.push_back(mk(6'h05, 0, 1, 4'd0, F1));
        tbl.push_back(mk(6'h05, 0, 1, 4'd1, DEC));
        tbl.push_back(mk(6'h05, 0, 1, 4'd8, BR_T));
        // J, JAL
        tbl.push_back(mk(6'h02, 0, 1, 4'd0, F1));
        tbl.push_back(mk(6'h02, 0, 1, 4'd1, DEC));
        tbl.push_back(mk(6'h02, 0, 1, 4'd9, JP));
        tbl.push_back(mk(6'h03, 0, 1, 4'd0, F1));
        tbl.push_back(mk(6'h03, 0, 1, 4'd1, DEC));
        tbl.push_back(mk(6'h03, 0, 1, 4'd9, JAL));
        tbl.push_back(mk(6'h00, 0, 1, 4'd0, F1));

        // reset state, observed while reset is held
        #1 reset = 1'b1;
        #2;
        n_vec++;
        if (state !== 4'd0 || act_ctl() !== RST) begin
            n_bad++;
            $display("FAIL reset_outputs: got state=%0d ctl=%h, expected state=0 ctl=%h",
                     state, act_ctl(), RST);
        end
        chk("reset_illegal", {3'b0, illegal_op}, 4'd0);
        chk("reset_timeout", {3'b0, mem_timeout}, 4'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++)
            run($sformatf("tbl[%0d]", i), tbl[i]);

        // illegal opcode: ERROR after DECODE, flag sticky until reset
        do_reset();
        run("ill_fetch", mk(6'h2B, 0, 1, 4'd0, F1));
        run("ill_decode", mk(6'h2B, 0, 1, 4'd1, DEC));
        for (int i = 0; i < 3; i++) begin
            run("ill_error", mk(6'h00, 0, 1, 4'd10, ERR));
            chk("ill_flag", {3'b0, illegal_op}, 4'd1);
        end
        chk("ill_no_timeout", {3'b0, mem_timeout}, 4'd0);
        do_reset();
        chk("ill_cleared", {3'b0, illegal_op}, 4'd0);
        chk("ill_state_fetch", state, 4'd0);

        // 14 waits then ready on the 15th cycle: no timeout
        for (int i = 0; i < 14; i++)
            run("wait14", mk(6'h00, 0, 0, 4'd0, F0));
        run("wait14_ready", mk(6'h00, 0, 1, 4'd0, F1));
        run("wait14_decode", mk(6'h00, 0, 1, 4'd1, DEC));
        chk("wait14_no_timeout", {3'b0, mem_timeout}, 4'd0);
        run("wait14_exec", mk(6'h00, 0, 1, 4'd5, EXR));
        run("wait14_wb", mk(6'h00, 0, 1, 4'd7, AW_R));

        // 15 consecutive waits in FETCH: timeout
        for (int i = 0; i < 15; i++)
            run("wait15", mk(6'h00, 0, 0, 4'd0, F0));
        run("timeout_error", mk(6'h00, 0, 1, 4'd10, ERR));
        chk("timeout_flag", {3'b0, mem_timeout}, 4'd1);
        run("timeout_hold", mk(6'h00, 0, 1, 4'd10, ERR));
        chk("timeout_sticky", {3'b0, mem_timeout}, 4'd1);
        do_reset();
        chk("timeout_cleared", {3'b0, mem_timeout}, 4'd0);

        // reset asserted in EXEC_I: back to FETCH at once, no write-back
        run("rst_fetch", mk(6'h08, 0, 1, 4'd0, F1));
        run("rst_decode", mk(6'h08, 0, 1, 4'd1, DEC));
        op = 6'h08;
        mem_ready = 1'b1;
        @(negedge clk);
        chk("rst_in_exec_i", state, 4'd6);
        #1 reset = 1'b1;
        #1;
        chk("rst_async_state", state, 4'd0);
        chk("rst_async_reg_write", {3'b0, reg_write}, 4'd0);
        chk("rst_async_pc_en", {3'b0, pc_en}, 4'd0);
        @(posedge clk);
        #1;
        chk("rst_hold_state", state, 4'd0);
        chk("rst_hold_reg_write", {3'b0, reg_write}, 4'd0);
        reset = 1'b0;
        run("rst_refetch", mk(6'h08, 0, 1, 4'd0, F1));
        run("rst_redecode", mk(6'h08, 0, 1, 4'd1, DEC));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter WAIT_LIMIT, default 15, SHALL be the number of consecutive not-ready memory cycles tolerated before a timeout.
REQ-002 clk  in  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 reset  in  1  SHALL be asynchronous, active-high.
REQ-004 op  in  6  SHALL be the instruction opcode from the instruction register.
REQ-005 zero  in  1  SHALL be the ALU zero flag.
REQ-006 mem_ready  in  1  SHALL indicate that the memory access completes this cycle.
REQ-007 pc_en  out  1 = PC write enable; pc_src  out  2 = 00 ALU result, 01 ALUOut, 10 jump target.
REQ-008 i_or_d  out  1 = 0 instruction address, 1 data address; mem_read  out  1; mem_write  out  1 (always 0); ir_write  out  1.
REQ-009 reg_dst  out  2 = 00 rt, 01 rd, 10 r31; mem_to_reg  out  2 = 00 ALUOut, 01 MDR, 10 PC; reg_write  out  1.
REQ-010 alu_src_a  out  1 = 0 PC, 1 A; alu_src_b  out  2 = 00 B, 01 constant 4, 10 sign-extended imm, 11 imm<<2.
REQ-011 alu_op  out  3 = 000 LUI, 001 sub, 010 pass, 011 add, 100 ADDI, 101 OR, 110 AND, 111 R-type funct.
REQ-012 state  out  4 = current state; retire  out  1 = last cycle of an instruction; illegal_op  out  1 (sticky); mem_timeout  out  1 (sticky).

Function
REQ-013 States and codes SHALL be: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, EXEC_R 5, EXEC_I 6, ALU_WB 7, BRANCH 8, JUMP 9, ERROR 10.
REQ-014 Outputs SHALL default to 0, with alu_op defaulting to 010, unless listed per state.
REQ-015 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=011, pc_src=00, and ir_write=pc_en=mem_ready (combinational); it advances to DECODE on mem_ready.
REQ-016 DECODE: op SHALL be registered into op_q, with alu_src_a=0, alu_src_b=11, alu_op=011 (branch target into ALUOut).
REQ-017 DECODE next state SHALL be: 0x00 -> EXEC_R; 0x08/0x0D/0x0C/0x0F -> EXEC_I; 0x23 -> MEM_ADDR; 0x04/0x05 -> BRANCH; 0x02/0x03 -> JUMP; any other opcode -> ERROR with illegal_op set.
REQ-018 EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=111, then ALU_WB.
REQ-019 EXEC_I: alu_src_a=1, alu_src_b=10, alu_op from op_q (ADDI 100, ORI 101, ANDI 110, LUI 000), then ALU_WB.
REQ-020 ALU_WB: reg_write=1, mem_to_reg=00, reg_dst=01 if op_q=0x00 else 00, retire=1, then FETCH.
REQ-021 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=011, then MEM_READ.
REQ-022 MEM_READ: mem_read=1, i_or_d=1; it advances to MEM_WB on mem_ready.
REQ-023 MEM_WB: reg_write=1, reg_dst=00, mem_to_reg=01, retire=1, then FETCH.
REQ-024 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_src=01, pc_en=(op_q=0x04 & zero)|(op_q=0x05 & !zero), retire=1, then FETCH.
REQ-025 JUMP: pc_src=10, pc_en=1, retire=1, then FETCH; for op_q=0x03 additionally reg_write=1, reg_dst=10, mem_to_reg=10.
REQ-026 Latency with mem_ready always high SHALL be: R/I-type 4 cycles, LW 5, BEQ/BNE/J/JAL 3.
REQ-027 Wait counter: increments each FETCH/MEM_READ cycle with mem_ready=0, clears on mem_ready or on leaving the state, and saturates.
REQ-028 If mem_ready=0 in the WAIT_LIMIT-th consecutive wait cycle, the next state SHALL be ERROR with mem_timeout set; mem_ready=1 in that cycle wins over the timeout.
REQ-029 ERROR: all enables SHALL be 0 and retire=0; the block stays in ERROR until reset.

Reset
REQ-030 Reset SHALL force state=FETCH, op_q=0, wait counter=0, illegal_op=0, mem_timeout=0.
REQ-031 While reset is asserted, pc_en, ir_write, reg_write, mem_read and mem_write SHALL be 0; other outputs take FETCH values.
REQ-032 Reset asserted mid-instruction SHALL abandon that instruction with no further register or PC write.

Verification
REQ-033 op=0x00, mem_ready=1 -> states 0,1,5,7; reg_write=1 with reg_dst=01 in cycle 4; retire pulses once.
REQ-034 op=0x23, mem_ready low 3 cycles in MEM_READ -> MEM_READ held 4 cycles, then MEM_WB with mem_to_reg=01; total 8 cycles.
REQ-035 op=0x04 with zero=1 -> pc_en=1 in BRANCH; op=0x05 with zero=1 -> pc_en=0 in BRANCH; pc_src=01 in both.
REQ-036 op=0x03 -> JUMP with pc_src=10, reg_dst=10, mem_to_reg=10, reg_write=1; op=0x02 -> reg_write=0.
REQ-037 op=0x2B -> ERROR after DECODE; illegal_op=1 persists until reset.
REQ-038 mem_ready held 0 in FETCH -> ERROR after 15 cycles with mem_timeout=1; reset asserted in EXEC_I -> FETCH immediately with no reg_write pulse.
